// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, the request payload and the op legality check.
// Imported by the arbiter and by the ALU decode.
package alu_pkg;

    localparam int unsigned ALU_CTRL_W = 5;
    localparam int unsigned DATA_W     = 32;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 5'b00000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 5'b00001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = 5'b00010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = 5'b00011;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = 5'b00100;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR   = 5'b00101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = 5'b00110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = 5'b00111;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = 5'b01000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = 5'b01001;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = 5'b01010;
    localparam logic [ALU_CTRL_W-1:0] ALU_NAND  = 5'b01011;
    localparam logic [ALU_CTRL_W-1:0] ALU_XNOR  = 5'b01100;
    localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = 5'b01101;
    localparam logic [ALU_CTRL_W-1:0] ALU_PASSA = 5'b01110;
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL   = 5'b10000;
    localparam logic [ALU_CTRL_W-1:0] ALU_ANDN  = 5'b10001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ORN   = 5'b10010;
    localparam logic [ALU_CTRL_W-1:0] ALU_MINU  = 5'b10011;
    localparam logic [ALU_CTRL_W-1:0] ALU_LUI   = 5'b10100;

    // Operands and op code of one ALU request.
    typedef struct packed {
        logic [ALU_CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0]     a;
        logic [DATA_W-1:0]     b;
    } alu_req_t;

    // Legal codes are the two contiguous ranges AND..PASSA and MUL..LUI.
    function automatic logic alu_op_legal(input logic [ALU_CTRL_W-1:0] op);
        return (op <= ALU_PASSA) || ((op >= ALU_MUL) && (op <= ALU_LUI));
    endfunction

endpackage

// File: rtl/alu_arb_rr2.sv
// Two-input ALU grant logic with round-robin pointer.
// Ports: clk, reset_n; cand0/cand1 (eligible requests in);
//        grant0_c/grant1_c (one-hot-or-zero grant, combinational).
module alu_arb_rr2 #(
    parameter bit PRIORITY_RR = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cand0,
    input  logic cand1,
    output logic grant0_c,
    output logic grant1_c
);

    // ptr = requester that wins the next tie (round-robin mode).
    logic ptr;

    // Tie goes to ptr in round-robin mode, else to requester 0.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (cand0 && cand1) begin
            if (PRIORITY_RR && ptr) begin
                grant1_c = 1'b1;
            end else begin
                grant0_c = 1'b1;
            end
        end else begin
            grant0_c = cand0;
            grant1_c = cand1;
        end
    end

    // After a grant to k the other requester gets the next tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if (PRIORITY_RR && (grant0_c || grant1_c)) begin
            ptr <= grant0_c;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the fetch (0) and execute (1) requesters.
// Ports: clk, reset_n; reqN_valid/ready/ctrl/a/b request side; rspN_valid/ready/
//        result/err response side; alu_control/alu_src_a/alu_src_b to the ALU,
//        alu_result back from it; clear_cnt and grant_cnt0/1 accept counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit          PRIORITY_RR = 1'b1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [4:0]        req0_ctrl,
    input  logic [4:0]        req1_ctrl,
    input  logic [31:0]       req0_a,
    input  logic [31:0]       req0_b,
    input  logic [31:0]       req1_a,
    input  logic [31:0]       req1_b,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    input  logic              rsp0_ready,
    input  logic              rsp1_ready,
    output logic [31:0]       rsp0_result,
    output logic [31:0]       rsp1_result,
    output logic              rsp0_err,
    output logic              rsp1_err,
    output logic [4:0]        alu_control,
    output logic [31:0]       alu_src_a,
    output logic [31:0]       alu_src_b,
    input  logic [31:0]       alu_result,
    input  logic              clear_cnt,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    logic     cand0, cand1;
    logic     grant0, grant1;
    logic     op_illegal;
    logic [DATA_W-1:0] capture_result;
    alu_req_t win_req;

    // A requester may issue only if its response slot is free or draining now;
    // reset_n gating keeps ready low while reset is held.
    assign cand0 = reset_n && req0_valid && (!rsp0_valid || rsp0_ready);
    assign cand1 = reset_n && req1_valid && (!rsp1_valid || rsp1_ready);

    alu_arb_rr2 #(
        .PRIORITY_RR (PRIORITY_RR)
    ) u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .cand0    (cand0),
        .cand1    (cand1),
        .grant0_c (grant0),
        .grant1_c (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Operand mux; idle ALU is parked on PASSA with zero operands.
    always_comb begin
        win_req = '{ctrl: ALU_PASSA, a: '0, b: '0};
        if (grant0) begin
            win_req = '{ctrl: req0_ctrl, a: req0_a, b: req0_b};
        end else if (grant1) begin
            win_req = '{ctrl: req1_ctrl, a: req1_a, b: req1_b};
        end
    end

    assign alu_control    = win_req.ctrl;
    assign alu_src_a      = win_req.a;
    assign alu_src_b      = win_req.b;
    assign op_illegal     = !alu_op_legal(win_req.ctrl);
    assign capture_result = op_illegal ? '0 : alu_result;

    // Response registers: accept loads new data, drain clears valid only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_err    <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_err    <= 1'b0;
        end else begin
            if (grant0) begin
                rsp0_valid  <= 1'b1;
                rsp0_result <= capture_result;
                rsp0_err    <= op_illegal;
            end else if (rsp0_ready) begin
                rsp0_valid  <= 1'b0;
            end
            if (grant1) begin
                rsp1_valid  <= 1'b1;
                rsp1_result <= capture_result;
                rsp1_err    <= op_illegal;
            end else if (rsp1_ready) begin
                rsp1_valid  <= 1'b0;
            end
        end
    end

    // Wrapping accept counters; clear wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (clear_cnt) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (grant0) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (grant1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters: fetch side (PC increment / branch-target arithmetic) and execute side (register operations). Arbitrates per cycle (round-robin or fixed priority), drives the ALU operand and control inputs from the granted request, and captures the ALU output into a per-requester response register. It sits between the fetch/execute stages and the ALU instance in the CPU datapath.

## Interface
- PRIORITY_RR, default 1: 1 means round-robin, 0 means fixed priority to requester 0.
- CNT_W, default 16: width of the grant counters.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req0_valid, req1_valid  in  1  request present
- req0_ready, req1_ready  out  1  request accepted this cycle
- req0_ctrl, req1_ctrl  in  5  ALU operation code
- req0_a, req0_b, req1_a, req1_b  in  32  operands, mapped to SrcA / SrcB
- rsp0_valid, rsp1_valid  out  1  response register full
- rsp0_ready, rsp1_ready  in  1  consumer takes the response
- rsp0_result, rsp1_result  out  32  captured ALU result
- rsp0_err, rsp1_err  out  1  the request carried an illegal op code
- alu_control  out  5  to the ALU's ALUControl input
- alu_src_a, alu_src_b  out  32  to the ALU's SrcA / SrcB inputs
- alu_result  in  32  from the ALU's ALUResult output (combinational)
- clear_cnt  in  1  synchronous clear of both grant counters
- grant_cnt0, grant_cnt1  out  CNT_W  accepted-request counters, wrapping

## Operation
- Eligibility:
  - eligN = !rspN_valid || rspN_ready.
  - Each requester has at most one result outstanding.
- Candidates: candN = reqN_valid && eligN.
- Grant:
  - Only one candidate: that candidate wins.
  - Both candidates, PRIORITY_RR=1: the winner is ptr.
  - Both candidates, PRIORITY_RR=0: the winner is requester 0.
- reqN_ready = grantN. It is combinational from valid and state. Requesters must not make valid depend on ready.
- ALU drive:
  - With a grant: alu_control/alu_src_a/alu_src_b = the winner's ctrl/a/b.
  - With no grant: alu_control=5'b01110 (pass SrcA), operands 0.
- Legal op codes: 5'b00000–5'b01110 and 5'b10000–5'b10100.
- Illegal op codes: 5'b01111 and anything above 5'b10100. The request is still accepted. The response carries result=0 and err=1. The ALU output is ignored.
- Capture on an accept edge:
  - rspN_valid <= 1.
  - rspN_result <= alu_result, or 0 if the op is illegal.
  - rspN_err <= illegal.
- Drain: rspN_valid && rspN_ready with no new accept: rspN_valid <= 0. result and err hold their values.
- Simultaneous drain and accept on the same requester: valid stays 1 and the new data replaces the old.
- Round-robin pointer: ptr resets to 0. After any grant to k (round-robin mode only), ptr <= 1-k. With no grant, ptr holds.
- Counters:
  - grant_cntN += 1 on each accept, wrapping at 2^CNT_W.
  - clear_cnt has priority over an increment in the same cycle.

## Timing
- Latency: a request accepted at edge N gives rspN_valid=1 and valid result after edge N. This is one cycle.
- Throughput: one accept per cycle in total. Each requester can accept every cycle as long as its consumer holds rspN_ready=1.
- The ALU path is combinational: requester operand mux → ALU → response register, all within one cycle.
- Reset values, applied asynchronously as soon as reset_n=0:
  - rsp*_valid=0, rsp*_result=0, rsp*_err=0.
  - ptr=0, grant_cnt*=0.
  - req*_ready=0 while reset_n=0.
- Reset mid-operation: in-flight and held results are discarded. No response is produced for them after deassertion.
- Deassertion is assumed synchronised upstream. The first grant is possible on the first edge with reset_n=1.

## Structure
- Shared package alu_pkg holds:
  - localparams for every ALU op code (ALU_AND=5'b00000 … ALU_LUI=5'b10100, ALU_PASSA=5'b01110);
  - function alu_op_legal(logic[4:0]).
- ALU decode also imports alu_pkg.
- One sub-module, alu_arb_rr2. It holds the two-input grant logic and the ptr register, with the PRIORITY_RR parameter.
- The response registers and counters stay in the top level.

## Test plan
- Single request: req0 ADD (00010) with a=5, b=7 → req0_ready=1 in the same cycle; next cycle rsp0_valid=1, rsp0_result=12, rsp0_err=0, grant_cnt0=1.
- Contention, continuous:
  - Both requesters valid, rsp*_ready=1, PRIORITY_RR=1 → grants alternate 0,1,0,1 starting with 0 after reset.
  - PRIORITY_RR=0 → req0 wins every cycle; req1 gets no grants.
- Backpressure:
  - rsp1_valid=1, rsp1_ready=0, req1_valid=1 → req1_ready=0, and req0 is granted every cycle.
  - Raise rsp1_ready → req1 is accepted in that same cycle; the next cycle shows the new rsp1_result.
- Illegal op: req1 ctrl=5'b01111 → accepted, rsp1_err=1, rsp1_result=0. Then ctrl=5'b10101 → same response.
- Signed and shift ops through the arbiter:
  - SLT (00111), a=0xFFFFFFFF, b=1 → result 1.
  - SRA (01000), a=4, b=0x80000000 → 0xF8000000.
  - LUI (10100), b=0x1234 → 0x12340000.
- Reset mid-operation: assert reset_n=0 while rsp0_valid=1 and grant_cnt0=3 → rsp0_valid, grant_cnt0 and ptr go to 0 immediately, with no clock edge needed. After release, requester 0 is granted first.
